// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder and its CPU controller.
// Holds the responder FSM state encoding and the default bus geometry
// (address width, data width, access latency) so the controller and the
// responder agree on them.
package memory_defs;

  localparam int DEF_ADDR_W  = 13;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/memory_responder_mem_array.sv
// mem_array: single-port synchronous RAM backing the unified
// instruction/data store. No reset; contents are undefined until written.
// Ports:
//   clk   - clock
//   en    - access enable for this cycle
//   we    - 1 = write wdata to addr, 0 = read addr into rdata
//   addr  - word address
//   wdata - write data
//   rdata - registered read data, changes only on an enabled read
module mem_array #(
  parameter int DATA_W = 8,
  parameter int AW     = 13,
  parameter int DEPTH  = 8192
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/memory_responder.sv
// memory_responder: multi-cycle memory target on a req/ack handshake.
// Accepts one request in IDLE, waits LATENCY cycles, commits the access on
// the edge entering RESP and pulses ack for one cycle.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   req, we, addr,
//   wdata           - request and its payload, sampled only in IDLE
//   rdata           - read data, valid with ack after a read, then held
//   ack             - one-cycle completion pulse
//   busy            - high in WAIT and RESP
//   err             - out-of-range flag, qualified by ack
// Build option: MEM_RANGE_CHECK_EN enables the address range check
// (err, write suppression, zero read data). Without it err is 0 and the
// address is truncated so out-of-range accesses alias into the array.
module memory_responder
  import memory_defs::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 8192,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  logic [3:0]        cnt;
  logic              ack_q;
  logic              busy_q;
  logic              err_q;
  logic              rd_valid;
  logic              rd_zero;

  logic              we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  logic              accept0;
  logic              wait_done;
  logic              commit;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              oor;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  // With zero latency the access commits on the accepting edge itself, so
  // the RAM is driven straight from the request inputs in that case.
  assign accept0   = (LATENCY == 0) && (state == ST_IDLE) && req;
  assign wait_done = (state == ST_WAIT) && (cnt == 4'd0);
  assign commit    = accept0 || wait_done;
  assign acc_we    = accept0 ? we    : we_c;
  assign acc_addr  = accept0 ? addr  : addr_c;
  assign acc_wdata = accept0 ? wdata : wdata_c;

`ifdef MEM_RANGE_CHECK_EN
  assign oor = ({1'b0, acc_addr} >= (ADDR_W+1)'(DEPTH));
`else
  assign oor = 1'b0;
`endif

  // Reset gates the enable so a commit can never land while rst is high.
  assign ram_en = commit && !oor && !rst;

  mem_array #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (acc_we),
    .addr  (acc_addr[MEM_AW-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // Capture registers carry data only, so they are not reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req) begin
      we_c    <= we;
      addr_c  <= addr;
      wdata_c <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_valid <= 1'b0;
      rd_zero  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            busy_q <= 1'b1;
            if (LATENCY == 0) begin
              state <= ST_RESP;
              ack_q <= 1'b1;
              err_q <= oor;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
            ack_q <= 1'b1;
            err_q <= oor;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
      // Read data source is tracked separately so writes leave rdata alone
      // and an out-of-range read presents zero until the next read.
      if (commit && !acc_we) begin
        rd_valid <= 1'b1;
        rd_zero  <= oor;
      end
    end
  end

  assign rdata = (rd_valid && !rd_zero) ? ram_rdata : '0;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_req = 1'b0, a_we = 1'b0;
  logic [12:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic [7:0]  a_rdata;
  logic        a_ack, a_busy, a_err;

  logic        b_req = 1'b0, b_we = 1'b0;
  logic [12:0] b_addr = '0;
  logic [7:0]  b_wdata = '0;
  logic [7:0]  b_rdata;
  logic        b_ack, b_busy, b_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_responder #(.ADDR_W(13), .DATA_W(8), .DEPTH(8192), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .rdata(a_rdata), .ack(a_ack), .busy(a_busy), .err(a_err)
  );

  memory_responder #(.ADDR_W(13), .DATA_W(8), .DEPTH(4096), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .rdata(b_rdata), .ack(b_ack), .busy(b_busy), .err(b_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction on DUT a (sel=0) or b (sel=1) starting in an IDLE
  // cycle and records what was seen over the next six cycles.
  task automatic xact(input bit sel, input logic w, input logic [12:0] ad,
                      input logic [7:0] wd, input bit scramble,
                      output int ack_cyc, output int ack_cnt,
                      output logic [5:0] busy_bits, output logic [7:0] rd,
                      output logic er);
    ack_cyc = -1; ack_cnt = 0; busy_bits = '0; rd = '0; er = 1'b0;
    if (sel) begin b_req = 1; b_we = w; b_addr = ad; b_wdata = wd; end
    else     begin a_req = 1; a_we = w; a_addr = ad; a_wdata = wd; end
    for (int c = 1; c <= 6; c++) begin
      step();
      busy_bits[c-1] = sel ? b_busy : a_busy;
      if (sel ? b_ack : a_ack) begin
        ack_cnt++;
        ack_cyc = c;
        rd = sel ? b_rdata : a_rdata;
        er = sel ? b_err : a_err;
      end
      if (c == 1) begin
        if (sel) b_req = 0; else a_req = 0;
        if (scramble) begin
          if (sel) begin b_we = ~w; b_addr = ~ad; b_wdata = ~wd; end
          else     begin a_we = ~w; a_addr = ~ad; a_wdata = ~wd; end
        end
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (a_ack !== 1'b0)  begin failures++; $display("FAIL reset_ack: got %b want 0", a_ack); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_err !== 1'b0)  begin failures++; $display("FAIL reset_err: got %b want 0", a_err); end
    checks++; if (a_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h want 00", a_rdata); end
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL reset_busy_b: got %b want 0", b_busy); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    int ac, an; logic [5:0] bb; logic [7:0] rd; logic er;
    xact(0, 1, 13'h0010, 8'hA5, 0, ac, an, bb, rd, er);
    checks++; if (ac !== 3) begin failures++; $display("FAIL wr_ack_cycle: got %0d want 3", ac); end
    checks++; if (an !== 1) begin failures++; $display("FAIL wr_ack_count: got %0d want 1", an); end
    checks++; if (bb !== 6'b000111) begin failures++; $display("FAIL wr_busy: got %b want 000111", bb); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr_err: got %b want 0", er); end
    xact(0, 0, 13'h0010, 8'h00, 0, ac, an, bb, rd, er);
    checks++; if (ac !== 3) begin failures++; $display("FAIL rd_ack_cycle: got %0d want 3", ac); end
    checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL rd_data: got %h want a5", rd); end
    checks++; if (a_rdata !== 8'hA5) begin failures++; $display("FAIL rd_hold: got %h want a5", a_rdata); end
    xact(0, 1, 13'h0011, 8'h5A, 0, ac, an, bb, rd, er);
    checks++; if (a_rdata !== 8'hA5) begin failures++; $display("FAIL wr_keeps_rdata: got %h want a5", a_rdata); end
  endtask

  task automatic test_wait_inputs_ignored();
    int ac, an; logic [5:0] bb; logic [7:0] rd; logic er;
    xact(0, 1, 13'h0030, 8'h3C, 1, ac, an, bb, rd, er);
    xact(0, 0, 13'h0030, 8'h00, 0, ac, an, bb, rd, er);
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL ign_write: got %h want 3c", rd); end
    xact(0, 1, 13'h0040, 8'h11, 0, ac, an, bb, rd, er);
    xact(0, 0, 13'h0040, 8'h00, 1, ac, an, bb, rd, er);
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL ign_read: got %h want 11", rd); end
    xact(0, 0, 13'h0040, 8'h00, 0, ac, an, bb, rd, er);
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL ign_read_noclobber: got %h want 11", rd); end
  endtask

  task automatic test_reset_mid_wait();
    int ac, an, acks; logic [5:0] bb; logic [7:0] rd; logic er;
    xact(0, 1, 13'h0020, 8'h11, 0, ac, an, bb, rd, er);
    a_req = 1; a_we = 1; a_addr = 13'h0020; a_wdata = 8'h3C;
    step();
    a_req = 0;
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL midwait_busy_before: got %b want 1", a_busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL midwait_busy_async: got %b want 0", a_busy); end
    #2 rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (a_ack) acks++;
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL midwait_no_ack: got %0d want 0", acks); end
    xact(0, 0, 13'h0020, 8'h00, 0, ac, an, bb, rd, er);
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL midwait_prior: got %h want 11", rd); end
  endtask

  task automatic test_reset_in_resp();
    int ac, an; logic [5:0] bb; logic [7:0] rd; logic er;
    a_req = 1; a_we = 1; a_addr = 13'h0050; a_wdata = 8'h99;
    step();
    a_req = 0;
    step();
    step();
    checks++; if (a_ack !== 1'b1) begin failures++; $display("FAIL resp_ack_before: got %b want 1", a_ack); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL resp_ack_async: got %b want 0", a_ack); end
    #2 rst = 1'b0;
    step();
    xact(0, 0, 13'h0050, 8'h00, 0, ac, an, bb, rd, er);
    checks++; if (rd !== 8'h99) begin failures++; $display("FAIL resp_committed: got %h want 99", rd); end
  endtask

  task automatic test_back_to_back();
    int ac, an; logic [5:0] bb; logic [7:0] rd; logic er;
    xact(1, 1, 13'h0000, 8'h12, 0, ac, an, bb, rd, er);
    checks++; if (ac !== 1) begin failures++; $display("FAIL l0_ack_cycle: got %0d want 1", ac); end
    checks++; if (bb !== 6'b000001) begin failures++; $display("FAIL l0_busy: got %b want 000001", bb); end
    xact(1, 1, 13'h0001, 8'h34, 0, ac, an, bb, rd, er);
    b_req = 1; b_we = 0; b_addr = 13'h0000;
    step();
    checks++; if (b_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack1: got %b want 1", b_ack); end
    checks++; if (b_rdata !== 8'h12) begin failures++; $display("FAIL b2b_data1: got %h want 12", b_rdata); end
    b_addr = 13'h0001;
    step();
    checks++; if (b_ack !== 1'b0) begin failures++; $display("FAIL b2b_ack2: got %b want 0", b_ack); end
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy2: got %b want 0", b_busy); end
    step();
    checks++; if (b_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack3: got %b want 1", b_ack); end
    checks++; if (b_rdata !== 8'h34) begin failures++; $display("FAIL b2b_data3: got %h want 34", b_rdata); end
    b_req = 0;
    step();
    checks++; if (b_ack !== 1'b0) begin failures++; $display("FAIL b2b_ack4: got %b want 0", b_ack); end
  endtask

`ifdef MEM_RANGE_CHECK_EN
  task automatic test_range();
    int ac, an; logic [5:0] bb; logic [7:0] rd; logic er;
    xact(1, 1, 13'h1000, 8'hFF, 0, ac, an, bb, rd, er);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL range_wr_err: got %b want 1", er); end
    checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL range_err_idle: got %b want 0", b_err); end
    xact(1, 0, 13'h0000, 8'h00, 0, ac, an, bb, rd, er);
    checks++; if (rd !== 8'h12) begin failures++; $display("FAIL range_no_alias: got %h want 12", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL range_inrange_err: got %b want 0", er); end
    xact(1, 0, 13'h1000, 8'h00, 0, ac, an, bb, rd, er);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL range_rd_zero: got %h want 00", rd); end
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL range_rd_err: got %b want 1", er); end
  endtask
`else
  task automatic test_alias();
    int ac, an; logic [5:0] bb; logic [7:0] rd; logic er;
    xact(1, 1, 13'h1005, 8'h77, 0, ac, an, bb, rd, er);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL alias_wr_err: got %b want 0", er); end
    xact(1, 0, 13'h0005, 8'h00, 0, ac, an, bb, rd, er);
    checks++; if (rd !== 8'h77) begin failures++; $display("FAIL alias_rd: got %h want 77", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL alias_rd_err: got %b want 0", er); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_wait_inputs_ignored();
    test_reset_mid_wait();
    test_reset_in_resp();
    test_back_to_back();
`ifdef MEM_RANGE_CHECK_EN
    test_range();
`else
    test_alias();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
